// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : UART frame receiver. Oversamples the line at CLKS_PER_BIT clocks
//            per bit, samples each bit at its midpoint, and checks parity and
//            the stop bit.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            rx         - asynchronous serial input, idle high
//            rx_data    - last received data word (held until next rx_vld)
//            rx_vld     - one-cycle pulse when a frame completes
//            parity_err - parity mismatch for the reported frame
//            frame_err  - stop bit was sampled low for the reported frame
//            busy       - receiver is inside a frame (not IDLE)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_vld,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    C_LAST = 3'(DATA_BITS - 1);
  localparam logic          C_ODD  = (PARITY_ODD != 0);
  localparam logic          C_PEN  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 rx_s1;
  logic                 rxs;
  logic                 rxs_d;
  logic [1:0]           warm;

  // The synchronizer and edge-detector flops come out of reset at 1, so a line
  // that is already low at release would look like a falling edge. Edges are
  // only honoured once every flop of the chain holds a real line sample.
  logic fall;
  assign fall = (warm == 2'd3) && rxs_d && !rxs;

  logic cnt_done;
  assign cnt_done = (cnt == C_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
      warm  <= 2'd0;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
      rxs_d <= rxs;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      rx_data    <= '0;
      rx_vld     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          cnt <= cnt + 1'b1;
          if (cnt == C_HALF) begin
            cnt <= '0;
            idx <= '0;
            if (!rxs) begin
              state <= DATA;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          cnt <= cnt + 1'b1;
          if (cnt_done) begin
            cnt        <= '0;
            idx        <= idx + 3'd1;
            shreg[idx] <= rxs;
            if (idx == C_LAST) state <= C_PEN ? PARITY : STOP;
          end
        end
        PARITY: begin
          cnt <= cnt + 1'b1;
          if (cnt_done) begin
            cnt     <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end
        end
        STOP: begin
          cnt <= cnt + 1'b1;
          if (cnt_done) begin
            // Leaving at mid-stop re-arms the edge detector in time for a
            // back-to-back start bit; results appear on the following cycle.
            cnt        <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            rx_vld     <= 1'b1;
            rx_data    <= shreg;
            frame_err  <= ~rxs;
            parity_err <= C_PEN & ((^shreg) ^ par_bit ^ C_ODD);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434: clk cycles per UART bit (115200 baud at 50 MHz); legal range 4..511.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, sent LSB first; legal range 5..8.
REQ-003 Parameter PARITY_EN, default 1: 1 means a parity bit follows the data bits; 0 means no parity bit.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
REQ-005 Port clk, input, 1: clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port rx, input, 1: asynchronous serial line; idle level 1.
REQ-008 Port rx_data, output, DATA_BITS: last received data word.
REQ-009 Port rx_vld, output, 1: one-cycle pulse; frame complete; rx_data, parity_err and frame_err are valid in that cycle.
REQ-010 Port parity_err, output, 1: received parity bit does not match computed parity.
REQ-011 Port frame_err, output, 1: stop bit sampled as 0.
REQ-012 Port busy, output, 1: high in every state except IDLE.

Function
REQ-013 Sync: rx passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rxs; the previous-cycle copy of rxs resets to 1.
REQ-014 States: IDLE, START, DATA, PARITY, STOP.
REQ-015 Bit counter cnt: ceil(log2(CLKS_PER_BIT)) bits wide; bit index idx: 3 bits.
REQ-016 IDLE: on a falling edge (rxs previous cycle=1, rxs now=0), go to START with cnt=0; no other exit.
REQ-017 START: cnt increments each cycle; at cnt==CLKS_PER_BIT/2-1 (integer division), sample rxs.
- rxs=0: go to DATA, cnt=0, idx=0.
- rxs=1: false start; go to IDLE, no rx_vld.
REQ-018 DATA: at cnt==CLKS_PER_BIT-1, sample rxs into shift position idx (LSB first), cnt=0, idx++.
- After sampling bit DATA_BITS-1: go to PARITY if PARITY_EN=1, else go to STOP.
REQ-019 PARITY: at cnt==CLKS_PER_BIT-1, sample the parity bit, cnt=0, go to STOP.
- Mismatch rule: XOR of data bits, XOR parity bit, XOR PARITY_ODD is nonzero.
REQ-020 STOP: at cnt==CLKS_PER_BIT-1, sample the stop bit, go to IDLE.
- Next cycle: rx_vld=1; rx_data=assembled word; frame_err=~stop bit; parity_err per REQ-019 (0 when PARITY_EN=0).
REQ-021 Latency: the stop sample occurs CLKS_PER_BIT/2 + (DATA_BITS+PARITY_EN+1)*CLKS_PER_BIT cycles after START entry; rx_vld follows exactly 1 cycle later.
REQ-022 Errored frames: rx_vld still pulses; rx_data still updates with the received bits.
REQ-023 Hold: rx_data, parity_err and frame_err keep their values until the next rx_vld.
REQ-024 Rearm: return to IDLE at mid-stop lets a falling edge of the next frame be caught with no lost cycles; back-to-back frames with no idle gap are received.
REQ-025 Break or stuck-low line: after a frame_err frame, no new frame starts until rxs has been 1 for at least one cycle and then falls.
REQ-026 No backpressure: rx_vld is not held or acknowledged; the consumer must capture data in the pulse cycle.

Reset
REQ-027 While rst_n=0, asynchronously:
- state=IDLE; cnt=0; idx=0; shift register=0; synchronizer flops=1.
- rx_data=0; rx_vld=0; parity_err=0; frame_err=0; busy=0.
REQ-028 Reset asserted mid-frame aborts the frame with no rx_vld; after release the block waits in IDLE for a fresh falling edge, even if rx is low at release.

Verification (CLKS_PER_BIT=434, DATA_BITS=8, PARITY_EN=1, PARITY_ODD=0 unless stated)
REQ-029 Good frame: send 0xA5 with parity 0 and stop 1 -> one rx_vld pulse 434/2 + 10*434 + 1 cycles after START entry; rx_data=0xA5; parity_err=0; frame_err=0; busy falls at mid-stop.
REQ-030 Parity error: send 0x3C with parity 1 -> rx_vld=1, rx_data=0x3C, parity_err=1, frame_err=0; repeat with PARITY_ODD=1 -> parity_err=0.
REQ-031 Framing error: send 0x55 with stop bit 0, hold rx low 2000 cycles, then release -> one rx_vld with frame_err=1 and rx_data=0x55; no second frame until rx rises and falls again.
REQ-032 Glitch: rx low for 100 cycles, then high -> START is entered, then IDLE is re-entered at the mid-start sample; no rx_vld; outputs unchanged.
REQ-033 Back-to-back: frames 0x00, 0xFF, 0x81 with no idle gap -> three rx_vld pulses, in order, with the correct data and no errors.
REQ-034 Reset mid-frame: assert rst_n=0 during DATA bit 4 of 0xC3 -> no rx_vld; all outputs 0; a following 0x5A frame is received correctly.
